// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divider helpers
// and the IO-page status bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int STAT_VALID_BIT     = 0;
  localparam int STAT_FRAME_ERR_BIT = 1;
  localparam int STAT_OVERRUN_BIT   = 2;

  // Clocks per bit; the emitter uses the same divider so both sides agree.
  function automatic int baud_div(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

  function automatic int baud_half(input int clk_freq_hz, input int baud_rate);
    return baud_div(clk_freq_hz, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RXD line; resets to the
// line's idle level so no false start bit is seen after reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a single-entry holding register, valid/ready
// handshake and sticky framing/overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int clk_freq_hz = 10_000_000,
  parameter int baud_rate   = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  input  logic       i_err_clr,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int DIV  = baud_div(clk_freq_hz, baud_rate);
  localparam int HALF = baud_half(clk_freq_hz, baud_rate);
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  logic rx_s;

  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          valid_q, valid_nxt;
  logic          frame_err_q, frame_err_nxt;
  logic          overrun_q, overrun_nxt;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_uart_rx),
    .q   (rx_s)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shreg       <= shreg_nxt;
      data_q      <= data_nxt;
      valid_q     <= valid_nxt;
      frame_err_q <= frame_err_nxt;
      overrun_q   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    data_nxt      = data_q;
    valid_nxt     = valid_q;
    frame_err_nxt = i_err_clr ? 1'b0 : frame_err_q;
    overrun_nxt   = i_err_clr ? 1'b0 : overrun_q;

    if (valid_q && i_ready) valid_nxt = 1'b0;

    // Set events below override the clear above when both hit one edge.
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = CNT_HALF;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_nxt   = DATA;
            cnt_nxt     = CNT_FULL;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_nxt = {rx_s, shreg[7:1]};
          cnt_nxt   = CNT_FULL;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_nxt = IDLE;
            if (!valid_q || i_ready) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
            end else begin
              overrun_nxt = 1'b1;
            end
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clocks per bit; line changes and
// output samples all happen on the falling clock edge.
module tb_uart_receiver;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_uart_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       i_err_clr;
  logic       o_frame_err;
  logic       o_overrun;

  int checks = 0;
  int errors = 0;

  uart_receiver #(.clk_freq_hz(10_000_000), .baud_rate(1_000_000)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .i_err_clr   (i_err_clr),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int ncyc);
    i_uart_rx = v;
    repeat (ncyc) @(negedge i_clk);
  endtask

  // Start bit plus eight data bits, LSB first; caller drives the stop bit.
  task automatic send_data(input logic [7:0] b);
    logic [7:0] t;
    t = b;
    drive(1'b0, 10);
    for (int i = 0; i < 8; i++) drive(t[i], 10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_data(b);
    drive(stop, 10);
  endtask

  task automatic pulse_ready();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
  endtask

  initial begin
    i_rst     = 1'b1;
    i_uart_rx = 1'b1;
    i_ready   = 1'b0;
    i_err_clr = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_data", o_data, 8'h00);
    check("rst_valid", o_valid, 1'b0);
    check("rst_frame_err", o_frame_err, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    i_rst = 1'b0;
    drive(1'b1, 20);

    // 0x55: valid must rise exactly after e97
    send_data(8'h55);
    drive(1'b1, 7);
    check("lat_valid_e96", o_valid, 1'b0);
    drive(1'b1, 1);
    check("lat_valid_e97", o_valid, 1'b1);
    check("data_55", o_data, 8'h55);
    drive(1'b1, 12);
    check("hold_valid_55", o_valid, 1'b1);
    pulse_ready();
    check("ready_drop", o_valid, 1'b0);
    check("ready_noeffect_err", o_overrun, 1'b0);

    // Back-to-back 0xA3, 0x3C without ready: overrun, first byte kept
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    drive(1'b1, 5);
    check("ovr_valid", o_valid, 1'b1);
    check("ovr_data", o_data, 8'hA3);
    check("ovr_flag", o_overrun, 1'b1);
    check("ovr_no_frame_err", o_frame_err, 1'b0);
    pulse_clr();
    check("ovr_cleared", o_overrun, 1'b0);
    check("ovr_clr_keeps_valid", o_valid, 1'b1);
    pulse_ready();
    check("ovr_consumed", o_valid, 1'b0);

    // 0x81 with low stop bit and a long break, then recovery with 0x42
    send_frame(8'h81, 1'b0);
    drive(1'b0, 300);
    check("brk_frame_err", o_frame_err, 1'b1);
    check("brk_no_valid", o_valid, 1'b0);
    drive(1'b1, 20);
    check("brk_still_no_valid", o_valid, 1'b0);
    send_frame(8'h42, 1'b1);
    drive(1'b1, 5);
    check("brk_rec_valid", o_valid, 1'b1);
    check("brk_rec_data", o_data, 8'h42);
    check("brk_flag_sticky", o_frame_err, 1'b1);
    pulse_clr();
    check("brk_flag_cleared", o_frame_err, 1'b0);
    pulse_ready();

    // Short low glitch on an idle line is ignored
    drive(1'b0, 3);
    drive(1'b1, 30);
    check("glitch_no_valid", o_valid, 1'b0);
    check("glitch_no_frame_err", o_frame_err, 1'b0);
    check("glitch_no_overrun", o_overrun, 1'b0);
    send_frame(8'h5A, 1'b1);
    drive(1'b1, 5);
    check("glitch_next_valid", o_valid, 1'b1);
    check("glitch_next_data", o_data, 8'h5A);
    check("glitch_next_no_overrun", o_overrun, 1'b0);
    pulse_ready();

    // Async reset in the middle of data bit 4 of 0xFF
    drive(1'b0, 10);
    drive(1'b1, 45);
    i_rst = 1'b1;
    #1;
    check("async_rst_data", o_data, 8'h00);
    check("async_rst_valid", o_valid, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(1'b1, 60);
    check("rst_partial_dropped", o_valid, 1'b0);
    send_frame(8'h17, 1'b1);
    drive(1'b1, 5);
    check("post_rst_valid", o_valid, 1'b1);
    check("post_rst_data", o_data, 8'h17);
    check("post_rst_no_err", {o_frame_err, o_overrun}, 2'b00);
    pulse_ready();

    // Hold 0x11, then accept it on the very edge 0x22 loads
    send_frame(8'h11, 1'b1);
    drive(1'b1, 3);
    check("hold_data_11", o_data, 8'h11);
    send_data(8'h22);
    drive(1'b1, 7);
    i_ready = 1'b1;
    drive(1'b1, 1);
    i_ready = 1'b0;
    check("same_edge_valid", o_valid, 1'b1);
    check("same_edge_data", o_data, 8'h22);
    check("same_edge_no_overrun", o_overrun, 1'b0);
    drive(1'b1, 10);
    pulse_ready();
    check("final_drop", o_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
